shift_frame_ctrl: RTL

SHIFT_FRAME_CTRL -- requirements
Module: shift_frame_ctrl

---
 rtl/shift_frame_ctrl_pkg.sv | 22 ++
 rtl/shift_frame_ctrl_shift_buffer.sv | 68 ++++++
 rtl/shift_frame_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/shift_frame_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// shift_frame_ctrl_pkg
// Shared definitions for the serial frame capture controller and its shift
// buffer: the controller FSM state encoding, the frame length and the width
// of the bit counters.
// -----------------------------------------------------------------------------
package shift_frame_ctrl_pkg;

  // Number of serial bits that make up one frame.
  localparam int FRAME_BITS = 17;

  // Width of the per-frame bit counters (must hold 0..FRAME_BITS).
  localparam int BITCOUNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/shift_frame_ctrl_shift_buffer.sv
// -----------------------------------------------------------------------------
// shift_frame_ctrl_shift_buffer  (ShiftBuffer)
// Serial-to-parallel shift register with valid/ready on both sides. Bits are
// shifted in MSB first, so the first accepted bit ends up in the top bit of
// the frame. Once FRAME_BITS bits are held the input stalls and the frame is
// offered on the output until taken.
//
// Ports:
//   clk              - clock
//   reset_buffer     - synchronous reload: empties the buffer
//   data_in_valid    - serial bit valid
//   data_in_ready    - buffer can take a bit (not yet full)
//   data_in_payload  - serial bit
//   data_out_valid   - a full frame is held
//   data_out_ready   - consumer takes the frame
//   data_out_payload - the assembled frame
// -----------------------------------------------------------------------------
module shift_frame_ctrl_shift_buffer
  import shift_frame_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_buffer,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  input  logic                  data_in_payload,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic [FRAME_BITS-1:0] data_out_payload
);

  logic [BITCOUNT_W-1:0] count_q, count_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic                  in_fire;
  logic                  out_fire;

  always_comb begin
    data_in_ready    = (count_q < BITCOUNT_W'(FRAME_BITS));
    data_out_valid   = (count_q == BITCOUNT_W'(FRAME_BITS));
    data_out_payload = shreg_q;
  end

  assign in_fire  = data_in_valid & data_in_ready;
  assign out_fire = data_out_valid & data_out_ready;

  // Input and output fires are mutually exclusive: input only while not full,
  // output only while full.
  always_comb begin
    count_d = count_q;
    shreg_d = shreg_q;
    if (reset_buffer) begin
      count_d = '0;
      shreg_d = '0;
    end else if (in_fire) begin
      shreg_d = {shreg_q[FRAME_BITS-2:0], data_in_payload};
      count_d = count_q + 1'b1;
    end else if (out_fire) begin
      count_d = '0;
    end
  end

  // Reloaded only through reset_buffer; the controller always passes through
  // its clearing state before the buffer's contents are used.
  always_ff @(posedge clk) begin
    count_q <= count_d;
    shreg_q <= shreg_d;
  end

endmodule

// File: rtl/shift_frame_ctrl.sv
// -----------------------------------------------------------------------------
// shift_frame_ctrl
// Frame capture controller. On io_frameStart it reloads the shift buffer,
// collects FRAME_BITS serial bits (first bit -> payload MSB), holds the
// finished frame and offers it on a valid/ready output. A SHIFT phase that
// idles for TIMEOUT_CYCLES, or that is restarted by a new io_frameStart, is
// aborted and counted in a saturating error counter.
//
// Parameters:
//   TIMEOUT_CYCLES - idle SHIFT cycles that abort a frame (2..255)
//   ERR_WIDTH      - width of the aborted-frame counter
// Ports:
//   Core_clk          - clock, rising edge
//   Core_resetn       - synchronous active-low reset
//   io_frameStart     - single-cycle request to start a capture
//   io_serial_valid   - serial bit valid
//   io_serial_ready   - serial bit accepted (SHIFT only)
//   io_serial_payload - serial bit
//   io_frame_valid    - captured frame available (DRAIN)
//   io_frame_ready    - consumer takes the frame
//   io_frame_payload  - captured frame
//   io_busy           - controller not idle
//   io_bitCount       - bits accepted in the current frame
//   io_errorCount     - saturating count of aborted frames
// -----------------------------------------------------------------------------
module shift_frame_ctrl
  import shift_frame_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ERR_WIDTH      = 8
) (
  input  logic                  Core_clk,
  input  logic                  Core_resetn,
  input  logic                  io_frameStart,
  input  logic                  io_serial_valid,
  output logic                  io_serial_ready,
  input  logic                  io_serial_payload,
  output logic                  io_frame_valid,
  input  logic                  io_frame_ready,
  output logic [FRAME_BITS-1:0] io_frame_payload,
  output logic                  io_busy,
  output logic [BITCOUNT_W-1:0] io_bitCount,
  output logic [ERR_WIDTH-1:0]  io_errorCount
);

  localparam int             TMO_W    = 8;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [BITCOUNT_W-1:0] bit_count_q, bit_count_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [ERR_WIDTH-1:0]  err_q, err_d;
  logic [FRAME_BITS-1:0] hold_q, hold_d;

  logic                  in_shift;
  logic                  reset_buffer;
  logic                  buf_in_valid;
  logic                  buf_in_ready;
  logic                  buf_out_valid;
  logic                  buf_out_ready;
  logic [FRAME_BITS-1:0] buf_out_payload;
  logic                  bit_accept;
  logic                  frame_fire;
  logic                  timeout_hit;
  logic                  restart;
  logic                  abort;

  function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  shift_frame_ctrl_shift_buffer u_shift_buffer (
    .clk              (Core_clk),
    .reset_buffer     (reset_buffer),
    .data_in_valid    (buf_in_valid),
    .data_in_ready    (buf_in_ready),
    .data_in_payload  (io_serial_payload),
    .data_out_valid   (buf_out_valid),
    .data_out_ready   (buf_out_ready),
    .data_out_payload (buf_out_payload)
  );

  assign in_shift = (state_q == ST_SHIFT);

  // Nothing enters the buffer while reset is asserted, so the buffer never
  // takes a bit the producer was told was not accepted.
  assign buf_in_valid = in_shift & io_serial_valid & Core_resetn;
  assign bit_accept   = buf_in_valid & buf_in_ready;
  assign frame_fire   = buf_out_valid & buf_out_ready;
  assign timeout_hit  = in_shift & ~bit_accept & (tmo_q == TMO_LAST);
  assign restart      = in_shift & io_frameStart;
  // A completed frame beats a coincident timeout; a restart beats both.
  assign abort        = restart | (timeout_hit & ~frame_fire);

  // State register
  always_ff @(posedge Core_clk) begin
    if (!Core_resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (io_frameStart) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (restart)          state_d = ST_CLEAR;
        else if (frame_fire)  state_d = ST_DRAIN;
        else if (timeout_hit) state_d = ST_IDLE;
      end
      ST_DRAIN: if (io_frame_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs; every external output is forced low while reset is asserted.
  always_comb begin
    reset_buffer     = (state_q == ST_CLEAR);
    buf_out_ready    = in_shift;
    io_serial_ready  = Core_resetn & in_shift & buf_in_ready;
    io_frame_valid   = Core_resetn & (state_q == ST_DRAIN);
    io_busy          = Core_resetn & (state_q != ST_IDLE);
    io_frame_payload = Core_resetn ? hold_q      : '0;
    io_bitCount      = Core_resetn ? bit_count_q : '0;
    io_errorCount    = Core_resetn ? err_q       : '0;
  end

  // Counters and holding register. Counters are cleared on entry to CLEAR so
  // the CLEAR cycle itself already shows a zero bit count.
  always_comb begin
    bit_count_d = bit_count_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    hold_d      = hold_q;
    if (state_d == ST_CLEAR) begin
      bit_count_d = '0;
      tmo_d       = '0;
    end else if (in_shift) begin
      if (bit_accept) begin
        bit_count_d = bit_count_q + 1'b1;
        tmo_d       = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
    if (in_shift && state_d == ST_DRAIN) begin
      hold_d = buf_out_payload;
    end
    if (abort) begin
      err_d = sat_inc(err_q);
    end
  end

  always_ff @(posedge Core_clk) begin
    if (!Core_resetn) begin
      bit_count_q <= '0;
      tmo_q       <= '0;
      err_q       <= '0;
      hold_q      <= '0;
    end else begin
      bit_count_q <= bit_count_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      hold_q      <= hold_d;
    end
  end

endmodule
